// File: rtl/dadda_pkg.sv
// Shared constants, FSM encoding and helpers for the time-shared 16x16 Dadda multiplier.
package dadda_pkg;

  localparam int HALF  = 8;
  localparam int OPW   = 16;
  localparam int PRODW = 32;

  localparam int SHIFT_S0 = 0;
  localparam int SHIFT_S1 = 8;
  localparam int SHIFT_S2 = 8;
  localparam int SHIFT_S3 = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int step_shift(input logic [1:0] step);
    case (step)
      2'd0:    return SHIFT_S0;
      2'd1:    return SHIFT_S1;
      2'd2:    return SHIFT_S2;
      default: return SHIFT_S3;
    endcase
  endfunction

  // 3:2 carry-save compressor on 16-bit rows; returns {carry, sum}.
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

endpackage

// File: rtl/dadda_8.sv
// Combinational 8x8 unsigned multiplier: partial-product rows reduced 8-6-4-3-2, then one adder.
module dadda_8
  import dadda_pkg::*;
(
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [15:0] pp [8];
  logic [31:0] r0, r1, r2, r3, r4, r5;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'b0, a_i & {8{b_i[i]}}} << i;
    end
  end

  // Height 8 -> 6 -> 4 -> 3 -> 2; all rows stay exact mod 2^16 since the product fits.
  assign r0 = csa(pp[0], pp[1], pp[2]);
  assign r1 = csa(pp[3], pp[4], pp[5]);
  assign r2 = csa(r0[15:0], r0[31:16], r1[15:0]);
  assign r3 = csa(r1[31:16], pp[6], pp[7]);
  assign r4 = csa(r2[15:0], r2[31:16], r3[15:0]);
  assign r5 = csa(r4[15:0], r4[31:16], r3[31:16]);

  assign p_o = r5[15:0] + r5[31:16];

endmodule

// File: rtl/dadda_16_seq.sv
// 16x16 unsigned multiplier that reuses one dadda_8 over four cycles, with valid/ready on both sides.
module dadda_16_seq
  import dadda_pkg::*;
#(
  parameter int HALF = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d;
  logic [PRODW-1:0]  acc_q, acc_d;
  logic [HALF-1:0]   op_a, op_b;
  logic [2*HALF-1:0] prod;

  // Step bit 0 picks the high byte of A, bit 1 the high byte of B.
  assign op_a = step_q[0] ? a_q[2*HALF-1:HALF] : a_q[HALF-1:0];
  assign op_b = step_q[1] ? b_q[2*HALF-1:HALF] : b_q[HALF-1:0];

  dadda_8 u_mul (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MUL;
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          step_d  = 2'd0;
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + (PRODW'(prod) << step_shift(step_q));
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_dadda_16_seq.sv
// Directed and randomized checks of dadda_16_seq against a plain A*B reference.
module tb_dadda_16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dadda_16_seq #(.HALF(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents a,b, waits for out_valid at exactly 4 edges after
  // acceptance, holds out_ready low for 'stall' cycles, then completes the handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                        input bit pulse_mul);
    logic [31:0] exp;
    exp = 32'(a) * 32'(b);
    check("in_ready_before", 32'(in_ready), 32'd1);
    A = a; B = b; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom;
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) begin
        check("out_valid_early", 32'(out_valid), 32'd0);
        check("y_zero_mul", y, 32'd0);
        check("busy_mul", 32'(busy), 32'd1);
        check("in_ready_mul", 32'(in_ready), 32'd0);
        if (pulse_mul && k == 1) begin
          A = 16'h0002; B = 16'h0003; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("out_valid_lat4", 32'(out_valid), 32'd1);
    check("product", y, exp);
    for (int s = 0; s < stall; s++) begin
      A = 16'h0002; B = 16'h0003; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("out_valid_hold", 32'(out_valid), 32'd1);
      check("y_hold", y, exp);
      check("in_ready_done", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_fall", 32'(out_valid), 32'd0);
    check("in_ready_rise", 32'(in_ready), 32'd1);
    check("y_idle", y, 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h1234, 16'h5678, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(16'h00FF, 16'h0100, 0, 1'b0);
    run_op(16'h0000, 16'hBEEF, 0, 1'b0);
    run_op(16'h1234, 16'h5678, 3, 1'b1);
    run_op(16'h00A5, 16'h0107, 0, 1'b0);

    // Reset while step 2 is pending: no out_valid afterwards.
    A = 16'hABCD; B = 16'h1357; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'd3, 16'd5, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
